// File: rtl/grok_dma_pkg.sv
// grok_dma_pkg
// Shared definitions for the block copy engine:
//   - state_e        : copy sequencer states
//   - DATA_WIDTH     : memory word width (16)
//   - overlap_check  : detects a destination window that starts inside the
//                      source window, ahead of the read pointer, which a
//                      forward word-by-word copy would corrupt
package grok_dma_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_COPY,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  // Operands are carried in 32 bits so the same function serves any address
  // width up to 32; aw selects the modulus for the distance computation.
  // A forward copy is only unsafe when the destination begins strictly after
  // the source and before the source's last word (1 <= d <= length-1).
  function automatic logic overlap_check(input logic [31:0] src,
                                         input logic [31:0] dst,
                                         input logic [31:0] length,
                                         input int          aw);
    logic [31:0] mask;
    logic [31:0] d;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    d    = (dst - src) & mask;
    return (length != 32'd0) && (d != 32'd0) && (d <= (length - 32'd1));
  endfunction

endpackage

// File: rtl/block_copy_engine.sv
// block_copy_engine
// Memory-to-memory copy initiator driving a one-cycle-latency synchronous
// memory: one read address per cycle, the returned word is written back to
// the destination on the following cycle through the shared write port.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   start                 request pulse, sampled only while busy=0
//   src, dst, length      first source word, first destination word, count
//   abort                 stop the copy in progress
//   busy                  transfer in progress
//   done                  one-cycle completion pulse
//   error                 one-cycle rejection pulse (unsafe overlap)
//   aborted               qualifies done when the copy was cut short
//   read_address          memory read address
//   read_data             memory data_out, valid one cycle after the address
//   write_enable          memory write strobe
//   write_address         memory write address
//   data_in               memory write data (pass-through of read_data)
module block_copy_engine
  import grok_dma_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] src,
  input  logic [ADDRESS_WIDTH-1:0] dst,
  input  logic [ADDRESS_WIDTH-1:0] length,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     aborted,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    data_in
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE = 1;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     aborted_q, aborted_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  // Reads still to be issued after the one currently on read_address.
  logic [ADDRESS_WIDTH-1:0] rd_left_q, rd_left_d;
  logic                     overlap;

  assign overlap = overlap_check(32'(src), 32'(dst), 32'(length), ADDRESS_WIDTH);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    aborted_d = 1'b0;
    we_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_left_d = rd_left_q;

    unique case (state_q)
      // FINISH behaves like IDLE so a new start is accepted while done is high.
      ST_IDLE, ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          if (overlap) begin
            error_d = 1'b1;
          end else if (length == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_PRIME;
            busy_d    = 1'b1;
            rd_addr_d = src;
            wr_addr_d = dst;
            rd_left_d = length - ONE;
          end
        end
      end

      // PRIME has issued the first read; from here every cycle writes the word
      // returned for the previous cycle's read. The first write goes to dst,
      // so the write pointer only advances once writes are already flowing.
      ST_PRIME, ST_COPY: begin
        if (abort) begin
          state_d   = ST_FINISH;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          we_d = 1'b1;
          if (state_q == ST_COPY) begin
            wr_addr_d = wr_addr_q + ONE;
          end
          if (rd_left_q == '0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d   = ST_COPY;
            rd_addr_d = rd_addr_q + ONE;
            rd_left_d = rd_left_q - ONE;
          end
        end
      end

      // The final write is on the bus this cycle; it commits regardless of
      // abort, which only sets the aborted qualifier.
      ST_DRAIN: begin
        state_d   = ST_FINISH;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        aborted_d = abort;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_left_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      aborted_q <= aborted_d;
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_left_q <= rd_left_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign aborted       = aborted_q;
  assign read_address  = rd_addr_q;
  assign write_enable  = we_q;
  assign write_address = wr_addr_q;
  assign data_in       = read_data;

endmodule

// File: tb/tb_block_copy_engine.sv
// tb_block_copy_engine
// Drives block_copy_engine against a behavioural 64K x 16 memory with one
// cycle read latency. The reference model is a snapshot of the source words
// taken at request time plus the overlap rule computed with plain integers.
module tb_block_copy_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src, dst, length;
  logic        abort;
  logic        busy, done, error, aborted;
  logic [15:0] read_address, write_address;
  logic [15:0] read_data, data_in;
  logic        write_enable;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] mem [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0, bd_data = '0;
  logic [15:0] wq_addr [$];
  logic [15:0] wq_data [$];
  int          wq_cyc  [$];

  block_copy_engine #(.ADDRESS_WIDTH(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .src           (src),
    .dst           (dst),
    .length        (length),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .aborted       (aborted),
    .read_address  (read_address),
    .read_data     (read_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .data_in       (data_in)
  );

  always #5 clock = ~clock;

  // Memory: synchronous read, write committed at the edge; log every DUT write
  // with the index of the edge that commits it.
  always @(posedge clock) begin
    cyc       <= cyc + 1;
    read_data <= mem[read_address];
    if (write_enable) begin
      mem[write_address] <= data_in;
      wq_addr.push_back(write_address);
      wq_data.push_back(data_in);
      wq_cyc.push_back(cyc + 1);
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic fill_random(input logic [15:0] base, input int n);
    logic [15:0] v;
    for (int k = 0; k < n; k++) begin
      v = 16'($urandom());
      poke(base + 16'(k), v);
    end
  endtask

  function automatic bit tb_overlap(input int s, input int d, input int n);
    int diff;
    diff = (((d - s) % 65536) + 65536) % 65536;
    return (n != 0) && (diff >= 1) && (diff <= n - 1);
  endfunction

  // Issues one request and checks it completely against the model.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                          input bit abort_at_start, input string name);
    logic [15:0] snap [$];
    logic [15:0] a;
    int          e0, wb, found, nw;
    bit          exp_err;
    exp_err = tb_overlap(int'(s), int'(d), n);
    for (int k = 0; k < n; k++) begin
      a = s + 16'(k);
      snap.push_back(mem[a]);
    end
    wb     = wq_addr.size();
    src    = s;
    dst    = d;
    length = 16'(n);
    start  = 1'b1;
    abort  = abort_at_start;
    tick();
    start  = 1'b0;
    abort  = 1'b0;
    e0     = cyc;

    if (exp_err) begin
      checks++;
      if (error !== 1'b1) $display("FAIL %s error_pulse got=%b exp=1", name, error);
      if (error !== 1'b1) errors++;
      checks++;
      if (busy !== 1'b0) begin
        $display("FAIL %s busy_on_reject got=%b exp=0", name, busy); errors++;
      end
      tick();
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL %s error_one_cycle got error=%b busy=%b exp=0 0", name, error, busy);
        errors++;
      end
      checks++;
      nw = wq_addr.size() - wb;
      if (nw != 0) begin
        $display("FAIL %s reject_writes got=%0d exp=0", name, nw); errors++;
      end
      return;
    end

    checks++;
    if (error !== 1'b0) begin
      $display("FAIL %s error_spurious got=%b exp=0", name, error); errors++;
    end
    checks++;
    if (busy !== (n != 0)) begin
      $display("FAIL %s busy_after_start got=%b exp=%b", name, busy, (n != 0)); errors++;
    end

    found = -1;
    for (int j = 0; j < n + 8; j++) begin
      if (j < n) begin
        checks++;
        a = s + 16'(j);
        if (read_address !== a) begin
          $display("FAIL %s read_address j=%0d got=%h exp=%h", name, j, read_address, a);
          errors++;
        end
      end
      if (done === 1'b1) begin
        found = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (found != ((n == 0) ? e0 : e0 + n + 1)) begin
      $display("FAIL %s done_edge got=%0d exp=%0d (start edge %0d, -1 = timeout)",
               name, found, (n == 0) ? e0 : e0 + n + 1, e0);
      errors++;
    end
    checks++;
    if (aborted !== 1'b0) begin
      $display("FAIL %s aborted got=%b exp=0", name, aborted); errors++;
    end
    checks++;
    nw = wq_addr.size() - wb;
    if (nw != n) begin
      $display("FAIL %s write_count got=%0d exp=%0d", name, nw, n); errors++;
    end
    for (int k = 0; k < n && k < nw; k++) begin
      checks++;
      if (wq_addr[wb+k] !== d + 16'(k) || wq_data[wb+k] !== snap[k] || wq_cyc[wb+k] != e0 + k + 2) begin
        $display("FAIL %s write k=%0d got addr=%h data=%h edge=%0d exp addr=%h data=%h edge=%0d",
                 name, k, wq_addr[wb+k], wq_data[wb+k], wq_cyc[wb+k], d + 16'(k), snap[k], e0 + k + 2);
        errors++;
      end
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      a = d + 16'(k);
      if (mem[a] !== snap[k]) begin
        $display("FAIL %s mem[%h] got=%h exp=%h", name, a, mem[a], snap[k]); errors++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    src     = '0;
    dst     = '0;
    length  = '0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0)    begin $display("FAIL reset busy got=%b exp=0", busy); errors++; end
    checks++; if (done !== 1'b0)    begin $display("FAIL reset done got=%b exp=0", done); errors++; end
    checks++; if (error !== 1'b0)   begin $display("FAIL reset error got=%b exp=0", error); errors++; end
    checks++; if (aborted !== 1'b0) begin $display("FAIL reset aborted got=%b exp=0", aborted); errors++; end
    checks++; if (write_enable !== 1'b0) begin
      $display("FAIL reset write_enable got=%b exp=0", write_enable); errors++;
    end
    checks++; if (read_address !== 16'h0) begin
      $display("FAIL reset read_address got=%h exp=0000", read_address); errors++;
    end
    checks++; if (write_address !== 16'h0) begin
      $display("FAIL reset write_address got=%h exp=0000", write_address); errors++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fill_random(16'h0100, 4);
    run_copy(16'h0100, 16'h0200, 4, 1'b0, "basic");
  endtask

  task automatic test_zero_len();
    run_copy(16'h0010, 16'h0050, 0, 1'b0, "zero_len");
    tick();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL zero_len done_pulse_width got=%b exp=0", done); errors++;
    end
  endtask

  task automatic test_overlap();
    fill_random(16'h0010, 4);
    run_copy(16'h0010, 16'h0012, 4, 1'b0, "overlap_reject");
    run_copy(16'h0010, 16'h000E, 4, 1'b0, "overlap_below");
    run_copy(16'h0040, 16'h0040, 3, 1'b0, "same_addr");
  endtask

  task automatic test_wrap();
    fill_random(16'hFFFE, 4);
    run_copy(16'hFFFE, 16'h0020, 4, 1'b0, "wrap");
  endtask

  task automatic test_abort();
    logic [15:0] ssnap [8];
    logic [15:0] dsnap [8];
    logic [15:0] a;
    int          wb, nw;
    fill_random(16'h0300, 8);
    fill_random(16'h0400, 8);
    for (int k = 0; k < 8; k++) begin
      a = 16'h0300 + 16'(k); ssnap[k] = mem[a];
      a = 16'h0400 + 16'(k); dsnap[k] = mem[a];
    end
    wb     = wq_addr.size();
    src    = 16'h0300;
    dst    = 16'h0400;
    length = 16'd8;
    start  = 1'b1;
    tick();             // E0
    start  = 1'b0;
    tick();             // E1
    tick();             // E2: first write committed, second on the bus
    abort  = 1'b1;
    tick();             // E3: second write committed, abort sampled
    abort  = 1'b0;
    checks++; if (done !== 1'b1) begin $display("FAIL abort done got=%b exp=1", done); errors++; end
    checks++; if (aborted !== 1'b1) begin $display("FAIL abort aborted got=%b exp=1", aborted); errors++; end
    checks++; if (write_enable !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort we_busy got we=%b busy=%b exp=0 0", write_enable, busy); errors++;
    end
    tick();
    checks++; if (done !== 1'b0 || aborted !== 1'b0) begin
      $display("FAIL abort pulse_width got done=%b aborted=%b exp=0 0", done, aborted); errors++;
    end
    nw = wq_addr.size() - wb;
    checks++; if (nw != 2) begin $display("FAIL abort write_count got=%0d exp=2", nw); errors++; end
    for (int k = 0; k < 8; k++) begin
      a = 16'h0400 + 16'(k);
      checks++;
      if (mem[a] !== ((k < 2) ? ssnap[k] : dsnap[k])) begin
        $display("FAIL abort mem[%h] got=%h exp=%h", a, mem[a], (k < 2) ? ssnap[k] : dsnap[k]);
        errors++;
      end
    end
    // abort with nothing in progress does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL abort_idle got busy=%b done=%b exp=0 0", busy, done); errors++;
    end
    fill_random(16'h0320, 5);
    run_copy(16'h0320, 16'h0420, 5, 1'b1, "start_with_abort");
  endtask

  task automatic test_reset_mid();
    fill_random(16'h0500, 8);
    src    = 16'h0500;
    dst    = 16'h0600;
    length = 16'd8;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || write_enable !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_mid async_clear got busy=%b we=%b done=%b exp=0 0 0", busy, write_enable, done);
      errors++;
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_mid after_release got busy=%b done=%b exp=0 0", busy, done); errors++;
    end
    run_copy(16'h0500, 16'h0600, 8, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    fill_random(16'h0700, 5);
    fill_random(16'h0800, 3);
    run_copy(16'h0700, 16'h0780, 5, 1'b0, "b2b_first");
    run_copy(16'h0800, 16'h0880, 3, 1'b0, "b2b_second");
    run_copy(16'h0900, 16'h0980, 0, 1'b0, "b2b_zero");
  endtask

  task automatic test_random();
    logic [15:0] s, d;
    int          n;
    for (int it = 0; it < 10; it++) begin
      s = 16'($urandom());
      d = s + 16'($urandom_range(0, 24)) - 16'd12;
      n = int'($urandom_range(0, 12));
      fill_random(s, n);
      run_copy(s, d, n, 1'b0, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overlap();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
